// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer
//   Captures a full parallel FFT frame on i_in_valid into a two-frame
//   ping-pong buffer and streams it out one complex bin per cycle over a
//   valid/ready handshake. Frames that arrive while both buffers are
//   occupied are dropped, which sets a sticky overflow flag and bumps a
//   saturating drop counter.
//
// Optional build macro:
//   FFT_SERIALIZER_FFTSHIFT_EN  stream DC-centred (bins N/2..N-1, then
//                               0..N/2-1). Undefined: natural order.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset_n      synchronous active-low reset
//   i_in_valid     one-cycle strobe, i_frame_in holds a complete frame
//   i_frame_in     parallel frame, element k is bin k
//   o_out_data     current bin sample
//   o_out_index    bin number of o_out_data
//   o_out_valid    beat valid
//   i_out_ready    consumer accepts the beat when valid && ready
//   o_out_last     final beat of the frame
//   o_overflow     sticky, set when a frame is dropped
//   o_drop_count   saturating count of dropped frames

package fft_pkg;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_product_t;
endpackage

module fft_frame_serializer
  import fft_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_in_valid,
  input  complex_product_t [N-1:0] i_frame_in,
  output complex_product_t         o_out_data,
  output logic [IDX_W-1:0]         o_out_index,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_out_last,
  output logic                     o_overflow,
  output logic [7:0]               o_drop_count
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                   r_state;
  logic [1:0]               r_count;
  logic                     r_wr_sel;
  logic                     r_rd_sel;
  logic [IDX_W-1:0]         r_beat;
  logic                     r_overflow;
  logic [7:0]               r_drop_count;
  complex_product_t [N-1:0] r_buf [2];

  logic                     w_valid;
  logic                     w_hs;
  logic                     w_last_hs;
  logic                     w_accept;
  logic [1:0]               w_count_nxt;
  logic [IDX_W-1:0]         w_map;

  assign w_valid = (r_state == S_STREAM);

`ifdef FFT_SERIALIZER_FFTSHIFT_EN
  // Wraps naturally at IDX_W bits because N is a power of two.
  assign w_map = r_beat + IDX_W'(N/2);
`else
  assign w_map = r_beat;
`endif

  assign w_hs      = w_valid & i_out_ready;
  assign w_last_hs = w_hs & (r_beat == IDX_W'(N-1));
  // With both buffers full, a frame is still taken if the streaming buffer
  // is released at this same edge; wr_sel equals rd_sel in that case.
  assign w_accept  = i_reset_n & i_in_valid & ((r_count != 2'd2) | w_last_hs);
  assign w_count_nxt = r_count + {1'b0, w_accept} - {1'b0, w_last_hs};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_count      <= 2'd0;
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_beat       <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      if (w_hs) begin
        if (w_last_hs) begin
          r_beat   <= '0;
          r_rd_sel <= ~r_rd_sel;
        end else begin
          r_beat   <= r_beat + IDX_W'(1);
        end
      end
      if (w_accept) begin
        r_wr_sel <= ~r_wr_sel;
      end else if (i_in_valid) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
      r_count <= w_count_nxt;
      r_state <= (w_count_nxt != 2'd0) ? S_STREAM : S_IDLE;
    end
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_buf[r_wr_sel] <= i_frame_in;
  end

  // Outputs are gated by valid so the unreset buffer never shows through.
  assign o_out_valid  = w_valid;
  assign o_out_data   = w_valid ? r_buf[r_rd_sel][w_map] : '0;
  assign o_out_index  = w_valid ? w_map : '0;
  assign o_out_last   = w_valid & (r_beat == IDX_W'(N-1));
  assign o_overflow   = r_overflow;
  assign o_drop_count = r_drop_count;

endmodule

// File: doc/fft_frame_serializer.md
# fft_frame_serializer

Downstream stage of the radix-2 FFT engine. Captures each N-point, bit-order-corrected parallel FFT frame on its valid strobe into a two-frame ping-pong buffer. Streams the frame out one complex bin per cycle over a valid/ready handshake, so the engine's one-cycle parallel output can feed serial consumers such as the equalizer and demapper. The FFT engine has no backpressure, so frames that arrive while both buffers are occupied are dropped and flagged.

## Interface
Parameters:
- N, 8: FFT size in bins; power of two, 8..256.
- IDX_W, $clog2(N): width of the bin index.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  one-cycle strobe; frame_in holds a complete frame (driven from the FFT out_valid).
- frame_in  in  complex_product_t [N-1:0]  parallel FFT frame; element k is bin k.
- out_data  out  complex_product_t  current bin.
- out_index  out  IDX_W  bin number of out_data.
- out_valid  out  1  out_data/out_index/out_last are valid.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- out_last  out  1  final beat of the frame.
- overflow  out  1  sticky; set when a frame is dropped.
- drop_count  out  8  saturating count of dropped frames.

## Operation
- Storage:
  - Two frame buffers, buf[0] and buf[1].
  - Write select wr_sel, read select rd_sel.
  - Occupancy count in 0..2.
  - Read beat counter beat in 0..N-1.
- Read FSM:
  - IDLE (count==0): out_valid=0.
  - STREAM (count>0): out_valid=1, out_data = buf[rd_sel][map(beat)], out_index = map(beat), out_last = (beat==N-1).
- Beat handshake (out_valid && out_ready):
  - Not last: beat increments.
  - Last: beat goes to 0, rd_sel toggles, count decrements.
  - If the other buffer is full, STREAM continues the next cycle with no bubble; otherwise the FSM returns to IDLE.
- Capture, on in_valid:
  - Accepted if count<2, or if count==2 and the last beat handshakes in the same cycle. In that case buf[wr_sel] (== rd_sel) is overwritten at the same edge it is released.
  - On accept: buf[wr_sel] <= frame_in, wr_sel toggles, count increments (net count unchanged on simultaneous release).
  - Otherwise the frame is dropped: buffers untouched, overflow <= 1, drop_count increments and saturates at 255.
- out_data, out_index and out_last are stable while out_valid && !out_ready. A capture never alters the buffer being streamed, except on the simultaneous-release edge.
- Samples pass through bit-exact; no arithmetic.
- map(beat) = beat by default (see Configuration).

## Timing
- Reset values while reset_n==0 at an edge:
  - Outputs: out_valid=0, out_last=0, out_index=0, out_data=0, overflow=0, drop_count=0.
  - Internal state: count=0, wr_sel=0, rd_sel=0, beat=0.
  - Buffer contents are not reset.
- Reset asserted mid-stream aborts the frame. No out_last is issued and the next accepted frame starts at beat 0.
- Latency: in_valid at edge t with count==0 gives out_valid=1, beat 0, at cycle t+1.
  - out_data, out_index and out_last are combinational from registered state; no combinational path from in_valid or frame_in to any output.
- Throughput: one bin per cycle with out_ready held high.
  - Sustains one frame per N cycles with no drop.
  - in_valid every N cycles is lossless.
- out_ready may toggle freely; out_valid never deasserts without a handshake while count>0.

## Configuration
- FFT_SERIALIZER_FFTSHIFT_EN:
  - Defined: map(beat) = (beat + N/2) mod N. Bins stream DC-centred (N/2..N-1, then 0..N/2-1). out_index reports the true bin number, and out_last coincides with bin N/2-1.
  - Undefined: map(beat) = beat, natural order 0..N-1.

## Test plan
- Single frame, N=8, bin k = {re:k, im:-k}, in_valid at cycle 0, out_ready=1:
  - out_valid cycles 1..8, out_index 0..7, data bit-exact.
  - out_last only at cycle 8.
  - out_valid=0 at cycle 9.
- Backpressure: out_ready low on beats 2 and 5 for 3 cycles each.
  - out_data and out_index held through each stall.
  - 8 beats delivered over 14 cycles; no duplicate or skip.
- Back-to-back: frames A and B at cycles 0 and 1, out_ready=1.
  - 16 consecutive valid beats, A then B, no bubble.
  - overflow stays 0.
- Overflow: frames at cycles 0, 1, 2 with out_ready=0.
  - Third frame dropped; overflow=1 and drop_count=1 from cycle 3.
  - Releasing out_ready yields frames 1 and 2 only.
- Simultaneous release: count==2 and third frame in_valid on the same edge as A's last handshake.
  - Accepted; drop_count stays 0.
  - Output streams B then C.
- Reset mid-stream: reset_n low for 1 cycle at beat 3.
  - All outputs 0, overflow cleared.
  - A new frame then streams from index 0. With FFT_SERIALIZER_FFTSHIFT_EN the order is 4,5,6,7,0,1,2,3 and out_last is on index 3.
